// File: rtl/defines_pkg.sv
// ---------------------------------------------------------------------------
// defines_pkg
// Shared SPU constants.
//   LS_SIZE : local-store capacity in bytes (power of two, at least 16)
// ---------------------------------------------------------------------------
package defines_pkg;
    localparam int LS_SIZE = 32768;
endpackage

// File: rtl/ls_access_unit.sv
// ---------------------------------------------------------------------------
// ls_access_unit
// Load/store issue unit for the SPU odd pipe. It is the initiator side of the
// local-store port. It accepts one quadword load or store per cycle and forms
// the quadword index. It drives the local-store write port and captures read
// data. Load results return on the writeback port a fixed LAT cycles after
// acceptance.
//
// Parameters
//   LS_BYTES : local-store size in bytes (power of two, >= 16)
//   LAT      : cycles from op acceptance to writeback (>= 2)
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   asynchronous active-low reset
//   op_valid     in   op presented this cycle (always accepted)
//   op_is_store  in   1 = store quadword, 0 = load quadword
//   op_ra        in   base address
//   op_imm       in   signed byte offset
//   op_rt_data   in   store data
//   op_rt_addr   in   load destination register
//   flush        in   kill all in-flight ops
//   ls_data_wr   out  local-store write data
//   ls_addr      out  local-store quadword index
//   ls_wr_en     out  local-store write strobe
//   ls_data_rd   in   local-store combinational read data
//   wb_en        out  load result valid
//   wb_addr      out  destination register
//   wb_data      out  loaded quadword
//   busy         out  at least one op in flight
// ---------------------------------------------------------------------------
module ls_access_unit #(
    parameter int LS_BYTES = defines_pkg::LS_SIZE,
    parameter int LAT      = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    input  logic         op_is_store,
    input  logic [31:0]  op_ra,
    input  logic [31:0]  op_imm,
    input  logic [127:0] op_rt_data,
    input  logic [6:0]   op_rt_addr,
    input  logic         flush,
    output logic [127:0] ls_data_wr,
    output logic [31:0]  ls_addr,
    output logic         ls_wr_en,
    input  logic [127:0] ls_data_rd,
    output logic         wb_en,
    output logic [6:0]   wb_addr,
    output logic [127:0] wb_data,
    output logic         busy
);

    // The mask wraps the address into the local store. It also clears the
    // byte-within-quadword bits in the same step.
    localparam logic [31:0] EA_MASK = 32'(LS_BYTES - 1) & ~32'hF;

    // Stage A holds the op that currently owns the local-store port.
    logic         a_valid;
    logic         a_is_store;
    logic [31:0]  a_index;
    logic [127:0] a_data;
    logic [6:0]   a_rt;

    // Stages 2..LAT form the load return chain. Stage LAT drives writeback.
    logic [LAT:2] s_valid;
    logic [127:0] s_data [2:LAT];
    logic [6:0]   s_rt   [2:LAT];

    logic [31:0]  ea_sum;
    logic [31:0]  ea;
    logic         accept;
    logic         capture;

    assign ea_sum  = op_ra + op_imm;
    assign ea      = ea_sum & EA_MASK;
    assign accept  = op_valid & ~flush;
    assign capture = a_valid & ~a_is_store & ~flush;

    // Stage A and the return chain. Payload registers only load when valid
    // data arrives. As a result, the port outputs and the writeback outputs
    // hold their last values across idle and flushed cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid    <= 1'b0;
            a_is_store <= 1'b0;
            a_index    <= '0;
            a_data     <= '0;
            a_rt       <= '0;
            s_valid    <= '0;
            for (int i = 2; i <= LAT; i++) begin
                s_data[i] <= '0;
                s_rt[i]   <= '0;
            end
        end else begin
            a_valid <= accept;
            if (accept) begin
                a_is_store <= op_is_store;
                a_index    <= ea >> 4;
                a_data     <= op_rt_data;
                a_rt       <= op_rt_addr;
            end

            // A store leaves stage A as a bubble. Only loads carry data onward.
            s_valid[2] <= capture;
            if (capture) begin
                s_data[2] <= ls_data_rd;
                s_rt[2]   <= a_rt;
            end

            for (int i = 3; i <= LAT; i++) begin
                s_valid[i] <= s_valid[i-1] & ~flush;
                if (s_valid[i-1] && !flush) begin
                    s_data[i] <= s_data[i-1];
                    s_rt[i]   <= s_rt[i-1];
                end
            end
        end
    end

    assign ls_addr    = a_index;
    assign ls_data_wr = a_data;
    // A flush must stop the pending store within its own cycle. The write
    // commits at the coming edge, so masking it later would be too late.
    assign ls_wr_en   = a_valid & a_is_store & ~flush & rst;

    assign wb_en   = s_valid[LAT];
    assign wb_addr = s_rt[LAT];
    assign wb_data = s_data[LAT];
    assign busy    = a_valid | (|s_valid);

endmodule

// File: tb/tb_ls_access_unit.sv
// ---------------------------------------------------------------------------
// tb_ls_access_unit
// Directed self-checking bench for ls_access_unit (LS_BYTES=32768, LAT=6).
// A small behavioural local store with combinational read sits on the port.
// Expected values are hand-computed constants or come from the pattern
// function below.
// ---------------------------------------------------------------------------
module tb_ls_access_unit;

    localparam int LAT = 6;
    localparam logic [127:0] BASIC = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] FILL_A5 = {16{8'hA5}};
    localparam logic [127:0] FILL_5A = {16{8'h5A}};
    localparam logic [127:0] FILL_3C = {16{8'h3C}};

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_is_store;
    logic [31:0]  op_ra;
    logic [31:0]  op_imm;
    logic [127:0] op_rt_data;
    logic [6:0]   op_rt_addr;
    logic         flush;
    logic [127:0] ls_data_wr;
    logic [31:0]  ls_addr;
    logic         ls_wr_en;
    logic [127:0] ls_data_rd;
    logic         wb_en;
    logic [6:0]   wb_addr;
    logic [127:0] wb_data;
    logic         busy;

    logic [127:0] mem [0:2047];
    logic         pre_en;
    logic [10:0]  pre_idx;
    logic [127:0] pre_data;

    int n_checks = 0;
    int n_fail   = 0;

    ls_access_unit #(.LS_BYTES(32768), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_is_store (op_is_store),
        .op_ra       (op_ra),
        .op_imm      (op_imm),
        .op_rt_data  (op_rt_data),
        .op_rt_addr  (op_rt_addr),
        .flush       (flush),
        .ls_data_wr  (ls_data_wr),
        .ls_addr     (ls_addr),
        .ls_wr_en    (ls_wr_en),
        .ls_data_rd  (ls_data_rd),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Local store: the read forwards the write data while a write is pending.
    // The write commits at the clock edge.
    assign ls_data_rd = ls_wr_en ? ls_data_wr : mem[ls_addr[10:0]];

    always @(posedge clk) begin
        if (ls_wr_en)
            mem[ls_addr[10:0]] <= ls_data_wr;
        else if (pre_en)
            mem[pre_idx] <= pre_data;
    end

    function automatic logic [127:0] pat(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] got,
                                input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic is_store, input logic [31:0] ra,
                                  input logic [31:0] imm, input logic [127:0] data,
                                  input logic [6:0] rt);
        op_valid    = 1'b1;
        op_is_store = is_store;
        op_ra       = ra;
        op_imm      = imm;
        op_rt_data  = data;
        op_rt_addr  = rt;
        tick;
        op_valid    = 1'b0;
    endtask

    task automatic preload(input logic [10:0] idx, input logic [127:0] data);
        pre_en   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        tick;
        pre_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; op_valid = 1'b0; op_is_store = 1'b0; op_ra = '0; op_imm = '0;
        op_rt_data = '0; op_rt_addr = '0; flush = 1'b0;
        pre_en = 1'b0; pre_idx = '0; pre_data = '0;
        #1;

        // Reset state
        check_output("rst_wb_en", wb_en, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_ls_wr_en", ls_wr_en, 0);
        check_output("rst_ls_addr", ls_addr, 0);
        check_output("rst_wb_data", wb_data, 0);
        check_output("rst_wb_addr", wb_addr, 0);

        for (int i = 0; i < 8; i++) preload(11'(i), pat(i));
        preload(11'h10, BASIC);
        preload(11'h20, pat(32));
        preload(11'h21, pat(33));
        preload(11'h22, pat(34));
        preload(11'h30, pat(48));
        rst = 1'b1;
        tick;
        tick;

        // Basic load: index 0x10 to r5, writeback six cycles after issue
        apply_stimulus(1'b0, 32'h100, 32'h0, '0, 7'd5);
        check_output("basic_ls_addr", ls_addr, 32'h10);
        check_output("basic_busy", busy, 1);
        check_output("basic_no_wr", ls_wr_en, 0);
        for (int i = 2; i <= 5; i++) begin
            tick;
            check_output("basic_no_early_wb", wb_en, 0);
        end
        tick;
        check_output("basic_wb_en", wb_en, 1);
        check_output("basic_wb_addr", wb_addr, 5);
        check_output("basic_wb_data", wb_data, BASIC);
        tick;
        check_output("basic_wb_one_cycle", wb_en, 0);
        check_output("basic_wb_data_hold", wb_data, BASIC);
        check_output("basic_busy_idle", busy, 0);

        // Address arithmetic and wrap
        apply_stimulus(1'b0, 32'h7FF8, 32'h18, '0, 7'd1);
        check_output("addr_wrap", ls_addr, 32'h1);
        apply_stimulus(1'b0, 32'h23, 32'hFFFFFFFD, '0, 7'd2);
        check_output("addr_neg_imm", ls_addr, 32'h2);
        apply_stimulus(1'b0, 32'hFFFFFFF0, 32'h20, '0, 7'd3);
        check_output("addr_32bit_wrap", ls_addr, 32'h1);
        apply_stimulus(1'b0, 32'h12345, 32'h0, '0, 7'd4);
        check_output("addr_mask", ls_addr, 32'h234);
        repeat (8) tick;
        check_output("addr_hold_idle", ls_addr, 32'h234);
        check_output("addr_last_wb_addr", wb_addr, 4);
        check_output("addr_busy_idle", busy, 0);

        // Streaming: eight back-to-back loads, indices and destinations 0..7
        for (int t = 0; t < 14; t++) begin
            if (t < 8) begin
                op_valid    = 1'b1;
                op_is_store = 1'b0;
                op_ra       = 32'(t * 16);
                op_imm      = 32'h0;
                op_rt_addr  = 7'(t);
            end else begin
                op_valid    = 1'b0;
            end
            tick;
            if (t >= 5 && t <= 12) begin
                check_output("stream_wb_en", wb_en, 1);
                check_output("stream_wb_addr", wb_addr, 128'(t - 5));
                check_output("stream_wb_data", wb_data, pat(t - 5));
            end else begin
                check_output("stream_no_wb", wb_en, 0);
            end
        end
        check_output("stream_busy_fall", busy, 0);

        // Store then load of the same index on the next cycle
        apply_stimulus(1'b1, 32'h70, 32'h0, FILL_A5, 7'd0);
        check_output("st_wr_en", ls_wr_en, 1);
        check_output("st_ls_addr", ls_addr, 32'h7);
        check_output("st_data_wr", ls_data_wr, FILL_A5);
        apply_stimulus(1'b0, 32'h70, 32'h0, '0, 7'd9);
        check_output("st_wr_one_cycle", ls_wr_en, 0);
        check_output("st_mem_written", mem[7], FILL_A5);
        for (int i = 0; i < 4; i++) begin
            tick;
            check_output("st_no_wb", wb_en, 0);
        end
        tick;
        check_output("ld_after_st_wb_en", wb_en, 1);
        check_output("ld_after_st_wb_addr", wb_addr, 9);
        check_output("ld_after_st_wb_data", wb_data, FILL_A5);
        tick;
        check_output("ld_after_st_wb_off", wb_en, 0);

        // Flush during the store's stage A cycle; the third op arrives with flush
        apply_stimulus(1'b0, 32'h200, 32'h0, '0, 7'd3);
        apply_stimulus(1'b1, 32'h210, 32'h0, FILL_5A, 7'd0);
        op_valid    = 1'b1;
        op_is_store = 1'b0;
        op_ra       = 32'h220;
        op_imm      = 32'h0;
        op_rt_addr  = 7'd4;
        flush       = 1'b1;
        #1;
        check_output("flush_store_in_a", ls_addr, 32'h21);
        check_output("flush_wr_masked", ls_wr_en, 0);
        tick;
        flush    = 1'b0;
        op_valid = 1'b0;
        check_output("flush_busy_clear", busy, 0);
        for (int i = 0; i < 8; i++) begin
            tick;
            check_output("flush_no_wb", wb_en, 0);
            check_output("flush_no_wr", ls_wr_en, 0);
        end
        check_output("flush_mem_unchanged", mem[33], pat(33));
        check_output("flush_wb_addr_hold", wb_addr, 9);
        check_output("flush_wb_data_hold", wb_data, FILL_A5);

        // Reset mid-operation with a load in flight and a store in stage A
        apply_stimulus(1'b0, 32'h100, 32'h0, '0, 7'd6);
        apply_stimulus(1'b1, 32'h300, 32'h0, FILL_3C, 7'd0);
        check_output("prerst_wr_en", ls_wr_en, 1);
        rst = 1'b0;
        #1;
        check_output("rst_mid_wb_en", wb_en, 0);
        check_output("rst_mid_busy", busy, 0);
        check_output("rst_mid_wr_en", ls_wr_en, 0);
        check_output("rst_mid_wb_data", wb_data, 0);
        check_output("rst_mid_wb_addr", wb_addr, 0);
        check_output("rst_mid_ls_addr", ls_addr, 0);
        tick;
        tick;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            check_output("rst_no_late_wb", wb_en, 0);
            check_output("rst_no_late_wr", ls_wr_en, 0);
        end
        check_output("rst_busy_after", busy, 0);
        check_output("rst_store_aborted", mem[48], pat(48));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
